// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: WISHBONE master that programs the i2c_opencores core once,
// then runs single-byte I2C register writes/reads and reports a status per command.
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE     = 16'd99,
  parameter logic [19:0] POLL_TIMEOUT = 20'd1000000
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rd_i,
  input  logic [6:0] cmd_dev_i,
  input  logic [7:0] cmd_reg_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic [1:0] rsp_status_o,
  output logic       init_done_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  input  logic       wbm_ack_i
);
  typedef enum logic [3:0] {S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_STO, S_SPOLL, S_RXR, S_RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] init_idx_q, init_idx_d, step_q, step_d, status_q, status_d;
  logic init_done_q, init_done_d, rd_q, rd_d, stb_q, stb_d, we_q, we_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d, dat_q, dat_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0] adr_q, adr_d, acc_adr;
  logic [7:0] acc_dat, txr_val, cr_val;
  logic acc_en, acc_we, poll, tmo, abort, done, tip, last, start;
  always_ff @(posedge wb_clk_i or negedge arst_i)
    if (!arst_i) begin
      state_q <= S_INIT;
      init_idx_q <= '0;
      init_done_q <= 1'b0;
      step_q <= '0;
      status_q <= '0;
      rd_q <= 1'b0;
      dev_q <= '0;
      reg_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      stb_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      init_idx_q <= init_idx_d;
      init_done_q <= init_done_d;
      step_q <= step_d;
      status_q <= status_d;
      rd_q <= rd_d;
      dev_q <= dev_d;
      reg_q <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
      we_q <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  assign txr_val = step_q == 2'd0 ? {dev_q, 1'b0} : step_q == 2'd1 ? reg_q : rd_q ? {dev_q, 1'b1} : wdata_q;
  assign cr_val  = step_q == 2'd0 ? 8'h90 : step_q == 2'd1 ? 8'h10 : step_q == 2'd3 ? 8'h68 : rd_q ? 8'h90 : 8'h50;
  assign poll  = state_q == S_POLL || state_q == S_SPOLL;
  assign tmo   = cnt_q >= POLL_TIMEOUT;
  // A timeout only aborts between polls, never in the middle of a bus cycle.
  assign abort = poll && tmo && !stb_q;
  assign done  = stb_q && wbm_ack_i;
  assign tip   = wbm_dat_i[1];
  assign last  = rd_q ? step_q == 2'd3 : step_q == 2'd2;
  assign start = acc_en && !stb_q && !abort;
  always_comb begin
    state_d = state_q;
    init_idx_d = init_idx_q;
    init_done_d = init_done_q;
    step_d = step_q;
    status_d = status_q;
    rd_d = rd_q;
    dev_d = dev_q;
    reg_d = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = poll ? cnt_q + {19'd0, !tmo} : 20'd0;
    stb_d = done ? 1'b0 : stb_q || start;
    adr_d = start ? acc_adr : adr_q;
    dat_d = start ? acc_dat : dat_q;
    we_d = start ? acc_we : we_q;
    case (state_q)
      S_INIT: if (done) begin
        init_idx_d = init_idx_q + 2'd1;
        state_d = init_idx_q == 2'd2 ? S_IDLE : S_INIT;
        init_done_d = init_idx_q == 2'd2;
      end
      S_IDLE: if (cmd_valid_i) begin
        rd_d = cmd_rd_i;
        dev_d = cmd_dev_i;
        reg_d = cmd_reg_i;
        wdata_d = cmd_wdata_i;
        step_d = 2'd0;
        status_d = 2'b00;
        state_d = S_TXR;
      end
      S_TXR: if (done) state_d = S_CR;
      S_CR: if (done) state_d = S_POLL;
      S_POLL:
        if (abort) begin
          status_d = 2'b11;
          state_d = S_STO;
        end else if (done && !tip) begin
          if (wbm_dat_i[5]) begin
            status_d = 2'b10;
            state_d = S_RESP;
          end else if (wbm_dat_i[7] && !(rd_q && step_q == 2'd3)) begin
            status_d = 2'b01;
            state_d = last ? S_RESP : S_STO;
          end else if (last) state_d = rd_q ? S_RXR : S_RESP;
          else begin
            step_d = step_q + 2'd1;
            state_d = rd_q && step_q == 2'd2 ? S_CR : S_TXR;
          end
        end
      S_STO: if (done) state_d = status_q == 2'b11 ? S_RESP : S_SPOLL;
      S_SPOLL: if (abort || (done && !tip)) state_d = S_RESP;
      S_RXR: if (done) begin
        rdata_d = wbm_dat_i;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end
  always_comb begin
    acc_en = 1'b1;
    acc_we = 1'b1;
    acc_adr = 3'd4;
    acc_dat = 8'h00;
    case (state_q)
      S_INIT: begin
        acc_adr = {1'b0, init_idx_q};
        acc_dat = init_idx_q == 2'd0 ? PRESCALE[7:0] : init_idx_q == 2'd1 ? PRESCALE[15:8] : 8'h80;
      end
      S_TXR: begin
        acc_adr = 3'd3;
        acc_dat = txr_val;
      end
      S_CR: acc_dat = cr_val;
      S_STO: acc_dat = 8'h40;
      S_POLL, S_SPOLL: acc_we = 1'b0;
      S_RXR: begin
        acc_we = 1'b0;
        acc_adr = 3'd3;
      end
      default: acc_en = 1'b0;
    endcase
  end
  assign cmd_ready_o  = state_q == S_IDLE;
  assign rsp_valid_o  = state_q == S_RESP;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_status_o = status_q;
  assign init_done_o  = init_done_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign wbm_we_o     = we_q;
  assign wbm_stb_o    = stb_q;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: drives commands into the sequencer against a behavioural
// i2c_opencores register model and compares bus writes and responses to a reference.
module tb_i2c_reg_sequencer;
  logic clk = 1'b0, arst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_rd = 1'b0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0, cmd_wdata = '0;
  logic cmd_ready, rsp_valid, init_done, wb_we, wb_stb;
  logic [7:0] rsp_rdata, wb_dat_o;
  logic [1:0] rsp_status;
  logic [2:0] wb_adr;
  logic [7:0] s_dat = '0;
  logic s_ack = 1'b0;

  i2c_reg_sequencer #(.PRESCALE(16'd99), .POLL_TIMEOUT(20'd100)) dut (
    .wb_clk_i(clk), .arst_i(arst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rd_i(cmd_rd),
    .cmd_dev_i(cmd_dev), .cmd_reg_i(cmd_reg), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_status_o(rsp_status),
    .init_done_o(init_done),
    .wbm_adr_o(wb_adr), .wbm_dat_o(wb_dat_o), .wbm_dat_i(s_dat),
    .wbm_we_o(wb_we), .wbm_stb_o(wb_stb), .wbm_ack_i(s_ack)
  );

  int errors = 0, checks = 0;
  int m_lat = 1, m_tip = 0, m_nack = -1, m_al = -1, m_hang = -1;
  logic [7:0] m_rx = '0;
  logic [2:0] log_adr[$];
  logic [7:0] log_dat[$];
  int log_cyc[$];
  logic [2:0] exp_adr[$];
  logic [7:0] exp_dat[$];
  logic [1:0] exp_status;
  int cyc = 0, lat_cnt = 0, tip_left = 0, cr_idx = 0;
  bit rxack = 0, al = 0, hang = 0;

  // Core model: byte index counts data-carrying CR writes since the command was accepted.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s_ack <= 1'b0;
      lat_cnt = 0;
      tip_left = 0;
      hang = 0;
      rxack = 0;
      al = 0;
    end else begin
      cyc++;
      s_ack <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        cr_idx = 0;
        hang = 0;
        rxack = 0;
        al = 0;
      end
      if (wb_stb && !s_ack) begin
        if (lat_cnt + 1 < m_lat) lat_cnt++;
        else begin
          lat_cnt = 0;
          s_ack <= 1'b1;
          if (wb_we) begin
            log_adr.push_back(wb_adr);
            log_dat.push_back(wb_dat_o);
            log_cyc.push_back(cyc);
            if (wb_adr == 3'd4) begin
              tip_left = m_tip;
              if (wb_dat_o == 8'h40) begin
                rxack = 0;
                al = 0;
                hang = 0;
              end else begin
                rxack = (cr_idx == m_nack) || wb_dat_o[5];
                al = cr_idx == m_al;
                hang = cr_idx == m_hang;
                cr_idx++;
              end
            end
          end else if (wb_adr == 3'd4) begin
            s_dat <= {rxack, 1'b0, al, 3'b000, (hang || tip_left > 0), 1'b0};
            if (tip_left > 0) tip_left--;
          end else s_dat <= (wb_adr == 3'd3) ? m_rx : 8'h00;
        end
      end
    end
  end

  // Reference: list of bytes per command, walked until the first fault ends it.
  function automatic void model(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int nb;
    exp_adr.delete();
    exp_dat.delete();
    exp_status = 2'b00;
    nb = rd ? 4 : 3;
    txr = '{{dev, 1'b0}, rg, rd ? {dev, 1'b1} : wd, 8'h00};
    cr = '{8'h90, 8'h10, rd ? 8'h90 : 8'h50, 8'h68};
    for (int i = 0; i < nb; i++) begin
      if (i < 3) begin
        exp_adr.push_back(3'd3);
        exp_dat.push_back(txr[i]);
      end
      exp_adr.push_back(3'd4);
      exp_dat.push_back(cr[i]);
      if (m_hang == i) begin
        exp_adr.push_back(3'd4);
        exp_dat.push_back(8'h40);
        exp_status = 2'b11;
        return;
      end
      if (m_al == i) begin
        exp_status = 2'b10;
        return;
      end
      if (m_nack == i && !(rd && i == 3)) begin
        exp_status = 2'b01;
        if (i < nb - 1) begin
          exp_adr.push_back(3'd4);
          exp_dat.push_back(8'h40);
        end
        return;
      end
    end
  endfunction

  task automatic test_cmd(input string name, input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    int base, n;
    logic [1:0] st;
    logic [7:0] rv;
    base = log_adr.size();
    model(rd, dev, rg, wd);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, cmd_ready); end
    cmd_valid = 1'b1; cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_rd = 1'($urandom); cmd_dev = 7'($urandom); cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s ready_drop: got %b want 0", name, cmd_ready); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_timeout: got no rsp_valid want pulse", name); return; end
    st = rsp_status;
    rv = rsp_rdata;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL %s pulse: got valid,ready=%b%b want 01", name, rsp_valid, cmd_ready); end
    checks++;
    if (log_adr.size() - base != exp_adr.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, log_adr.size() - base, exp_adr.size());
    end else
      for (int i = 0; i < exp_adr.size(); i++) begin
        checks++;
        if (log_adr[base+i] !== exp_adr[i] || log_dat[base+i] !== exp_dat[i]) begin
          errors++;
          $display("FAIL %s write%0d: got (%0d,%h) want (%0d,%h)", name, i, log_adr[base+i], log_dat[base+i], exp_adr[i], exp_dat[i]);
        end
      end
    checks++;
    if (st !== exp_status) begin errors++; $display("FAIL %s status: got %b want %b", name, st, exp_status); end
    if (rd && exp_status == 2'b00) begin
      checks++;
      if (rv !== m_rx) begin errors++; $display("FAIL %s rdata: got %h want %h", name, rv, m_rx); end
    end
  endtask

  task automatic check_init(input string name);
    int base, n;
    logic [7:0] want[3];
    want = '{8'h63, 8'h00, 8'h80};
    base = log_adr.size();
    @(negedge clk);
    arst_n = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if ({init_done, cmd_ready} !== 2'b11) begin errors++; $display("FAIL %s done_ready: got %b%b want 11", name, init_done, cmd_ready); end
    checks++;
    if (log_adr.size() - base != 3) begin errors++; $display("FAIL %s init_count: got %0d want 3", name, log_adr.size() - base); end
    else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_adr[base+i] !== 3'(i) || log_dat[base+i] !== want[i]) begin
          errors++;
          $display("FAIL %s init%0d: got (%0d,%h) want (%0d,%h)", name, i, log_adr[base+i], log_dat[base+i], i, want[i]);
        end
      end
  endtask

  task automatic test_reset();
    m_lat = 1;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_status, init_done, wb_adr, wb_dat_o, wb_we, wb_stb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h status=%b done=%b stb=%b", cmd_ready, rsp_valid, rsp_rdata, rsp_status, init_done, wb_stb);
    end
    repeat (3) @(negedge clk);
    check_init("reset");
  endtask

  task automatic test_write();
    m_lat = 1; m_tip = 1; m_nack = -1; m_al = -1; m_hang = -1;
    test_cmd("write", 1'b0, 7'h50, 8'h10, 8'hA5);
  endtask

  task automatic test_read();
    m_lat = 1; m_tip = 2; m_nack = -1; m_al = -1; m_hang = -1; m_rx = 8'h33;
    test_cmd("read", 1'b1, 7'h1D, 8'h0F, 8'h00);
  endtask

  task automatic test_nack();
    m_lat = 1; m_tip = 1; m_nack = 0; m_al = -1; m_hang = -1;
    test_cmd("nack_addr", 1'b0, 7'h7F, 8'h22, 8'h5A);
  endtask

  task automatic test_timeout();
    int base, d;
    m_lat = 1; m_tip = 0; m_nack = -1; m_al = -1; m_hang = 0;
    base = log_adr.size();
    test_cmd("timeout", 1'b0, 7'h21, 8'h03, 8'h44);
    if (log_adr.size() - base == 3) begin
      d = log_cyc[base+2] - log_cyc[base+1];
      checks++;
      if (d < 100 || d > 115) begin errors++; $display("FAIL timeout_latency: got %0d cycles want 100..115", d); end
    end
    m_hang = -1;
  endtask

  task automatic test_back_to_back();
    int f;
    for (int k = 0; k < 24; k++) begin
      m_lat = $urandom_range(1, 3);
      m_tip = $urandom_range(0, 3);
      f = $urandom_range(0, 3);
      m_nack = f == 2 ? $urandom_range(0, 3) : -1;
      m_al = f == 3 ? $urandom_range(0, 3) : -1;
      m_hang = -1;
      m_rx = 8'($urandom);
      test_cmd("random", 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int base, n;
    m_lat = 2; m_tip = 3; m_nack = -1; m_al = -1; m_hang = -1;
    base = log_adr.size();
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_dev = 7'h1D; cmd_reg = 8'h0F;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!(log_adr.size() - base >= 3 && wb_stb === 1'b1) && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (wb_stb !== 1'b1) begin errors++; $display("FAIL mid_read_stb: got %b want 1", wb_stb); end
    #1 arst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_status, init_done, wb_adr, wb_dat_o, wb_we, wb_stb} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ready=%b valid=%b done=%b adr=%0d dat=%h we=%b stb=%b", cmd_ready, rsp_valid, init_done, wb_adr, wb_dat_o, wb_we, wb_stb);
    end
    repeat (2) @(negedge clk);
    check_init("reinit");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Upstream command engine for the i2c_opencores wrapper. Acts as the sole WISHBONE master on its 3-bit/8-bit register port. Programs prescale and enable once after reset, then executes single-byte I2C register transactions: a write is dev/reg/data; a read is dev/reg, then repeated-start, dev+R, and a NACKed byte. Each command gets a status/data response; user logic never touches core registers.

Parameters:
PRESCALE, 16'd99, value written to PRERlo/PRERhi (SCL = wb_clk / (5*(PRESCALE+1))).
POLL_TIMEOUT, 20'd1000000, max wb_clk cycles spent polling SR.TIP for one byte before abort.

Ports:
wb_clk_i  in  1  clock, shared with the I2C core.
arst_i  in  1  asynchronous active-low reset.
cmd_valid_i  in  1  command request.
cmd_ready_o  out  1  high only in IDLE after init; command accepted when valid&ready.
cmd_rd_i  in  1  1 = read, 0 = write.
cmd_dev_i  in  7  7-bit slave address.
cmd_reg_i  in  8  slave register index.
cmd_wdata_i  in  8  write data (ignored on read).
rsp_valid_o  out  1  one-cycle pulse when a command completes.
rsp_rdata_o  out  8  read byte, valid with rsp_valid_o; holds until next response.
rsp_status_o  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 poll timeout.
init_done_o  out  1  high once core programming completes.
wbm_adr_o  out  3  core register address (0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR).
wbm_dat_o  out  8  write data to core.
wbm_dat_i  in  8  read data from core.
wbm_we_o  out  1  write enable.
wbm_stb_o  out  1  strobe (core derives cyc from stb).
wbm_ack_i  in  1  core acknowledge.

Behaviour:
- Reset (arst_i=0, async): all outputs 0, rsp_rdata_o=0, FSM to INIT0. Reset mid-transaction abandons the bus cycle immediately; the core is reset separately.
- Bus access: drive adr/dat/we and stb=1; hold all until wbm_ack_i=1; on the ack cycle, capture wbm_dat_i (reads) and drop stb. Minimum one stb-low cycle between accesses. Never issue back-to-back stb.
- Init: write PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=0x80. Then init_done_o=1 and go to IDLE. Init runs once per reset.
- IDLE: cmd_ready_o=1. On valid&ready, latch all cmd fields and drop ready the next cycle.
- Byte step = write TXR, write CR, then poll SR (read addr 4) until bit1 TIP=0, with the timeout counter reset at the CR write.
- After each step, check in priority order:
  - SR bit5 AL=1 -> status 10, no STOP issued.
  - SR bit7 RxACK=1 on any address/data byte -> status 01, write CR=0x40 (STO), poll TIP=0, respond.
  - Timeout -> status 11, write CR=0x40, respond without polling.
- Write sequence: {TXR=dev<<1, CR=0x90}, {TXR=reg, CR=0x10}, {TXR=wdata, CR=0x50}. A NACK on the final byte reports 01; STO is already issued, so no extra STOP.
- Read sequence: {TXR=dev<<1, CR=0x90}, {TXR=reg, CR=0x10}, {TXR=dev<<1|1, CR=0x90}, {CR=0x68 (RD|STO|NACK)}, poll TIP=0, read RXR (addr 3) into rsp_rdata_o. RxACK is not checked on the data byte.
- Response: rsp_valid_o pulses one cycle with status, then return to IDLE; cmd_ready_o reasserts the cycle after the pulse. Minimum 1 idle cycle between commands.
- Interrupt output of the core is unused: IF is never cleared via IACK, and polling relies on TIP only.
- cmd_* changes while busy are ignored.

Test Plan:
- Reset release with ack model 1-cycle latency -> exactly three writes: (0,0x63), (1,0x00), (2,0x80). Then init_done_o=1 and cmd_ready_o=1.
- Write dev=0x50 reg=0x10 data=0xA5, slave ACKs all -> TXR/CR writes 0xA0/0x90, 0x10/0x10, 0xA5/0x50; rsp_status=00.
- Read dev=0x1D reg=0x0F, slave returns 0x33 -> CR 0x90, 0x10, 0x90 (TXR=0x3B), 0x68; rsp_rdata=0x33, status=00.
- Write to absent dev=0x7F (RxACK=1 after address) -> CR=0x40 issued, no further TXR writes, status=01.
- Core holds TIP=1 with POLL_TIMEOUT=100 -> abort within 100 cycles plus one bus access, CR=0x40, status=11.
- Assert arst_i low while stb is high mid-read -> all outputs 0 the same cycle. After release, the init sequence repeats.
